// File: rtl/rtmc_stepper_pkg.sv
// Shared types and defaults for the rtmc_stepper multi-channel sequencer.
// Optional feature macro: RTMC_STEP_PULSE_EN.
package rtmc_stepper_pkg;

    localparam int NUM_CH_DEF      = 2;
    localparam int POS_W_DEF       = 32;
    localparam int DELAY_W_DEF     = 32;
    localparam int TABLE_DEPTH_DEF = 16;
    localparam int MC_W_DEF        = 8;
    localparam int PHASE_W         = $clog2(TABLE_DEPTH_DEF);

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_STEP  = 2'd2
    } step_state_t;

endpackage

// File: rtl/rtmc_step_channel.sv
// One stepper channel: delay/step FSM, step counter, position and limits.
// RTMC_STEP_PULSE_EN adds registered step pulse and latched direction outputs.
module rtmc_step_channel
    import rtmc_stepper_pkg::*;
#(
    parameter int POS_W   = POS_W_DEF,
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int PH_W    = PHASE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               dir_i,
    input  logic               pos_clr_i,
    input  logic [POS_W-1:0]   step_count_i,
    input  logic [DELAY_W-1:0] step_delay_i,
    input  logic [POS_W-1:0]   limit_pos_i,
    input  logic [POS_W-1:0]   limit_neg_i,
    output logic [PH_W-1:0]    phase_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               limit_hit_o,
    output logic [POS_W-1:0]   position_o
`ifdef RTMC_STEP_PULSE_EN
    ,
    output logic               step_pulse_o,
    output logic               dir_out_o
`endif
);

    step_state_t        state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d, dly_q, dly_d;
    logic [POS_W-1:0]   rem_q, rem_d, pos_q, pos_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               dir_q, dir_d, hit_q, hit_d, done_q, done_d;
    logic               legal;

    assign legal = dir_q ? ($signed(pos_q) < $signed(limit_pos_i))
                         : ($signed(pos_q) > $signed(limit_neg_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            phase_q <= '0;
            dir_q   <= 1'b0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        hit_d   = hit_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pos_clr_i) pos_d = '0;
                if (start_i && !stop_i) begin
                    if (step_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = step_count_i;
                        dly_d   = step_delay_i;
                        cnt_d   = step_delay_i;
                        dir_d   = dir_i;
                        hit_d   = 1'b0;
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STEP: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (!legal) begin
                    hit_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // phase wraps naturally: table depth is a power of two
                    phase_d = dir_q ? phase_q + 1'b1 : phase_q - 1'b1;
                    pos_d   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == POS_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = dly_q;
                        state_d = S_DELAY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign phase_o     = phase_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign limit_hit_o = hit_q;
    assign position_o  = pos_q;

`ifdef RTMC_STEP_PULSE_EN
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) pulse_q <= 1'b0;
        else     pulse_q <= (state_q == S_STEP) && !stop_i && legal;
    end

    assign step_pulse_o = pulse_q;
    assign dir_out_o    = dir_q;
`endif

endmodule

// File: rtl/rtmc_stepper.sv
// Multi-channel stepper: shared motor-state table plus registered coil outputs.
// RTMC_STEP_PULSE_EN exposes step_pulse/dir_out for external step/dir drivers.
module rtmc_stepper
    import rtmc_stepper_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int DELAY_W     = DELAY_W_DEF,
    parameter int TABLE_DEPTH = TABLE_DEPTH_DEF,
    parameter int MC_W        = MC_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              start,
    input  logic [NUM_CH-1:0]              stop,
    input  logic [NUM_CH-1:0]              dir,
    input  logic [NUM_CH-1:0]              oe,
    input  logic [NUM_CH-1:0]              pos_clr,
    input  logic [NUM_CH*POS_W-1:0]        step_count,
    input  logic [NUM_CH*DELAY_W-1:0]      step_delay,
    input  logic [NUM_CH*POS_W-1:0]        limit_pos,
    input  logic [NUM_CH*POS_W-1:0]        limit_neg,
    input  logic                           tbl_we,
    input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr,
    input  logic [MC_W-1:0]                tbl_wdata,
    output logic [NUM_CH*MC_W-1:0]         mc_out,
    output logic [NUM_CH-1:0]              busy,
    output logic [NUM_CH-1:0]              done,
    output logic [NUM_CH-1:0]              limit_hit,
    output logic [NUM_CH*POS_W-1:0]        position
`ifdef RTMC_STEP_PULSE_EN
    ,
    output logic [NUM_CH-1:0]              step_pulse,
    output logic [NUM_CH-1:0]              dir_out
`endif
);

    localparam int AW = $clog2(TABLE_DEPTH);

    logic [MC_W-1:0]        tbl_q [TABLE_DEPTH];
    logic [AW-1:0]          phase [NUM_CH];
    logic [NUM_CH*MC_W-1:0] mc_q, mc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) tbl_q[i] <= '0;
            mc_q <= '0;
        end else begin
            if (tbl_we) tbl_q[tbl_addr] <= tbl_wdata;
            mc_q <= mc_d;
        end
    end

    // lookup uses the pre-write table, so a same-cycle write shows a cycle later
    always_comb begin
        mc_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mc_d[c*MC_W +: MC_W] = oe[c] ? tbl_q[phase[c]] : '0;
        end
    end

    assign mc_out = mc_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rtmc_step_channel #(
            .POS_W   (POS_W),
            .DELAY_W (DELAY_W),
            .PH_W    (AW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .start_i      (start[c]),
            .stop_i       (stop[c]),
            .dir_i        (dir[c]),
            .pos_clr_i    (pos_clr[c]),
            .step_count_i (step_count[c*POS_W +: POS_W]),
            .step_delay_i (step_delay[c*DELAY_W +: DELAY_W]),
            .limit_pos_i  (limit_pos[c*POS_W +: POS_W]),
            .limit_neg_i  (limit_neg[c*POS_W +: POS_W]),
            .phase_o      (phase[c]),
            .busy_o       (busy[c]),
            .done_o       (done[c]),
            .limit_hit_o  (limit_hit[c]),
            .position_o   (position[c*POS_W +: POS_W])
`ifdef RTMC_STEP_PULSE_EN
            ,
            .step_pulse_o (step_pulse[c]),
            .dir_out_o    (dir_out[c])
`endif
        );
    end

endmodule

// File: tb/tb_rtmc_stepper.sv
// Directed scoreboard bench for rtmc_stepper (default parameters).
module tb_rtmc_stepper;

    localparam int NCH = 2;
    localparam int PW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  start, stop, dir, oe, pos_clr;
    logic [NCH*PW-1:0] step_count, limit_pos, limit_neg;
    logic [NCH*DW-1:0] step_delay;
    logic            tbl_we;
    logic [3:0]      tbl_addr;
    logic [MW-1:0]   tbl_wdata;
    logic [NCH*MW-1:0] mc_out;
    logic [NCH-1:0]  busy, done, limit_hit;
    logic [NCH*PW-1:0] position;
`ifdef RTMC_STEP_PULSE_EN
    logic [NCH-1:0]  step_pulse, dir_out;
`endif

    always #5 clk = ~clk;

    rtmc_stepper dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .oe         (oe),
        .pos_clr    (pos_clr),
        .step_count (step_count),
        .step_delay (step_delay),
        .limit_pos  (limit_pos),
        .limit_neg  (limit_neg),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .mc_out     (mc_out),
        .busy       (busy),
        .done       (done),
        .limit_hit  (limit_hit),
        .position   (position)
`ifdef RTMC_STEP_PULSE_EN
        ,
        .step_pulse (step_pulse),
        .dir_out    (dir_out)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    int dk0, dk1, dc0, dc1;
    logic [1:0] b0, h0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ev(input int ch, input int k,
                                       input logic [7:0] v);
        return {16'd0, 16'(ch), 24'(k), v};
    endfunction

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_mc observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic cfg(input int ch, input logic d, input logic [31:0] cnt,
                       input logic [31:0] dly, input logic [31:0] lp,
                       input logic [31:0] ln);
        dir[ch]                = d;
        step_count[ch*PW +: PW] = cnt;
        step_delay[ch*DW +: DW] = dly;
        limit_pos[ch*PW +: PW]  = lp;
        limit_neg[ch*PW +: PW]  = ln;
    endtask

    task automatic reset_load();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tbl_we    = 1'b1;
            tbl_addr  = 4'(i);
            tbl_wdata = 8'(1 << i);
            @(negedge clk);
        end
        tbl_addr  = 4'd15;
        tbl_wdata = 8'h80;
        @(negedge clk);
        tbl_we = 1'b0;
        @(negedge clk);
    endtask

    // k = number of the rising edge since the start was sampled (first = 0)
    task automatic watch(input int ncyc, input int stop_k, input logic [1:0] smask,
                         output int d0, output int d1, output int c0,
                         output int c1, output logic [1:0] bz, output logic [1:0] ht);
        logic [7:0] p0, p1;
        p0 = mc_out[7:0];
        p1 = mc_out[15:8];
        d0 = -1; d1 = -1; c0 = 0; c1 = 0;
        bz = '0; ht = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            start = '0;
            stop  = (k == stop_k - 1) ? smask : 2'b00;
            if (k == 0) begin
                bz = busy;
                ht = limit_hit;
            end
            if (done[0]) begin c0++; if (d0 < 0) d0 = k; end
            if (done[1]) begin c1++; if (d1 < 0) d1 = k; end
            if (mc_out[7:0] !== p0) pop_chk(ev(0, k, mc_out[7:0]));
            if (mc_out[15:8] !== p1) pop_chk(ev(1, k, mc_out[15:8]));
            p0 = mc_out[7:0];
            p1 = mc_out[15:8];
        end
    endtask

    initial begin
        start = '0; stop = '0; dir = '0; oe = '0; pos_clr = '0;
        step_count = '0; step_delay = '0; limit_pos = '0; limit_neg = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mc", 64'(mc_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hit", 64'(limit_hit), 64'd0);
        chk("rst_pos", 64'(position), 64'd0);

        // forward 3 steps, delay 2
        reset_load();
        oe = 2'b01;
        cfg(0, 1'b1, 3, 2, 100, 32'(-100));
        @(negedge clk);
        chk("mc_idle", 64'(mc_out[7:0]), 64'h01);
        push("mc_fwd", ev(0, 5, 8'h02));
        push("mc_fwd", ev(0, 9, 8'h04));
        push("mc_fwd", ev(0, 13, 8'h08));
        start = 2'b01;
        watch(16, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("fwd_busy", 64'(b0[0]), 64'd1);
        chk("fwd_done_at", 64'(dk0), 64'd12);
        chk("fwd_done_cnt", 64'(dc0), 64'd1);
        chk("fwd_pos", 64'(position[31:0]), 64'd3);
        chk("fwd_idle", 64'(busy[0]), 64'd0);
        chk("fwd_sb_empty", 64'(exp_q.size()), 64'd0);

        // reverse 1 step from phase 0 wraps to entry 15
        reset_load();
        cfg(0, 1'b0, 1, 1, 100, 32'(-100));
        push("mc_wrap", ev(0, 4, 8'h80));
        start = 2'b01;
        watch(6, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("rev_done_at", 64'(dk0), 64'd3);
        chk("rev_pos", 64'(position[31:0]), 64'hFFFF_FFFF);
        chk("rev_sb_empty", 64'(exp_q.size()), 64'd0);

        // upper limit stops the move at position 2
        pos_clr = 2'b01;
        @(negedge clk);
        pos_clr = 2'b00;
        chk("pos_clr", 64'(position[31:0]), 64'd0);
        cfg(0, 1'b1, 5, 0, 2, 32'(-100));
        push("mc_lim", ev(0, 3, 8'h01));
        push("mc_lim", ev(0, 5, 8'h02));
        start = 2'b01;
        watch(10, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("lim_done_at", 64'(dk0), 64'd6);
        chk("lim_done_cnt", 64'(dc0), 64'd1);
        chk("lim_hit", 64'(limit_hit[0]), 64'd1);
        chk("lim_pos", 64'(position[31:0]), 64'd2);
        cfg(0, 1'b0, 1, 0, 2, 32'(-100));
        push("mc_back", ev(0, 3, 8'h01));
        start = 2'b01;
        watch(6, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("hit_cleared", 64'(h0[0]), 64'd0);
        chk("back_done_at", 64'(dk0), 64'd2);
        chk("back_pos", 64'(position[31:0]), 64'd1);

        // abort during the first delay
        cfg(0, 1'b1, 10, 5, 100, 32'(-100));
        start = 2'b01;
        watch(8, 3, 2'b01, dk0, dk1, dc0, dc1, b0, h0);
        chk("stop_done_at", 64'(dk0), 64'd3);
        chk("stop_done_cnt", 64'(dc0), 64'd1);
        chk("stop_pos", 64'(position[31:0]), 64'd1);
        chk("stop_busy", 64'(busy[0]), 64'd0);
        chk("stop_sb_empty", 64'(exp_q.size()), 64'd0);

        // two channels together, ch1 outputs disabled
        pos_clr = 2'b01;
        @(negedge clk);
        pos_clr = 2'b00;
        cfg(0, 1'b1, 4, 0, 100, 32'(-100));
        cfg(1, 1'b1, 4, 3, 100, 32'(-100));
        push("mc_dual", ev(0, 3, 8'h02));
        push("mc_dual", ev(0, 5, 8'h04));
        push("mc_dual", ev(0, 7, 8'h08));
        push("mc_dual", ev(0, 9, 8'h00));
        start = 2'b11;
        watch(24, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("dual_done0", 64'(dk0), 64'd8);
        chk("dual_done1", 64'(dk1), 64'd20);
        chk("dual_pos0", 64'(position[31:0]), 64'd4);
        chk("dual_pos1", 64'(position[63:32]), 64'd4);
        chk("dual_mc1_off", 64'(mc_out[15:8]), 64'd0);
        chk("dual_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef RTMC_STEP_PULSE_EN
        chk("dir_out", 64'(dir_out), 64'd3);
`endif

        // start+stop together, then zero-length start
        cfg(0, 1'b1, 3, 0, 100, 32'(-100));
        start = 2'b01;
        stop  = 2'b01;
        watch(4, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("ss_no_done", 64'(dc0), 64'd0);
        chk("ss_no_busy", 64'(b0[0]), 64'd0);
        cfg(0, 1'b1, 0, 0, 100, 32'(-100));
        start = 2'b01;
        watch(3, -1, 2'b00, dk0, dk1, dc0, dc1, b0, h0);
        chk("zero_done_at", 64'(dk0), 64'd0);
        chk("zero_done_cnt", 64'(dc0), 64'd1);
        chk("zero_no_busy", 64'(b0[0]), 64'd0);

        // same-cycle write of the entry being read (ch0 phase is 4)
        tbl_we    = 1'b1;
        tbl_addr  = 4'd4;
        tbl_wdata = 8'h55;
        @(negedge clk);
        tbl_we = 1'b0;
        chk("tbl_old", 64'(mc_out[7:0]), 64'h00);
        @(negedge clk);
        chk("tbl_new", 64'(mc_out[7:0]), 64'h55);
        oe = 2'b00;
        @(negedge clk);
        chk("oe_off", 64'(mc_out[7:0]), 64'h00);

        // reset in the middle of a move
        oe = 2'b01;
        cfg(0, 1'b1, 5, 1, 100, 32'(-100));
        start = 2'b01;
        @(negedge clk);
        start = 2'b00;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pos", 64'(position), 64'd0);
        chk("mid_rst_mc", 64'(mc_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
